// File: rtl/cpu_run_monitor_pkg.sv
// Shared types and constants for the CPU run/termination monitor.
// Optional build macro: CPU_RUN_MONITOR_CYCLES_EN (frozen cycle-count outputs).
package cpu_run_monitor_pkg;

    // Per-channel lifecycle: armed by start, watches for a held NOP,
    // samples the stack once, then holds its verdict.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        HOLD  = 3'd2,
        CHECK = 3'd3,
        FIN   = 3'd4
    } mon_state_t;

    localparam logic [7:0] NOP_OPCODE = 8'h00;

    localparam int OP_W  = 8;
    localparam int PTR_W = 16;
    localparam int VAL_W = 32;

    // Exactly one bit is set once a channel reaches FIN, none before.
    typedef struct packed {
        logic pass;
        logic fail;
        logic timeout;
    } chan_result_t;

endpackage

// File: rtl/run_mon_channel.sv
// One monitor channel: run FSM, cycle budget counter, NOP-hold counter
// and the end-of-run stack compare.
// Optional build macro: CPU_RUN_MONITOR_CYCLES_EN adds the frozen cycle count.
import cpu_run_monitor_pkg::*;

module run_mon_channel #(
    parameter int MAX_CYCLES = 250,
    parameter int NOP_HOLD   = 4,
    parameter int CYC_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OP_W-1:0]  op_code,
    input  logic [PTR_W-1:0] tos_ptr,
    input  logic [VAL_W-1:0] tos_val,
    input  logic [PTR_W-1:0] exp_ptr,
    input  logic [VAL_W-1:0] exp_val,
    input  logic             val_chk_en,
    output logic [2:0]       state_dbg,
    output logic             pass,
    output logic             fail,
    output logic             timeout
`ifdef CPU_RUN_MONITOR_CYCLES_EN
    ,
    output logic [CYC_W-1:0] cycles
`endif
);

    // Wide enough to hold the value NOP_HOLD itself.
    localparam int NW = $clog2(NOP_HOLD + 1);
    localparam logic [NW-1:0]    NOP_ONE = NW'(1);
    localparam logic [NW-1:0]    NOP_TGT = NW'(NOP_HOLD);
    localparam logic [CYC_W-1:0] CYC_LIM = CYC_W'(MAX_CYCLES - 1);

    mon_state_t   state_q;
    logic [CYC_W-1:0] cyc_q;
    logic [NW-1:0]    nop_q;
    chan_result_t res_q;

    logic             is_nop;
    logic             at_limit;
    logic [CYC_W-1:0] cyc_inc;
    logic [NW-1:0]    nop_inc;
    logic             term_run;
    logic             term_hold;
    logic             ptr_ok;
    logic             val_ok;

    assign is_nop    = (op_code == NOP_OPCODE);
    assign at_limit  = (cyc_q == CYC_LIM);
    assign cyc_inc   = (cyc_q == {CYC_W{1'b1}}) ? cyc_q : cyc_q + 1'b1;
    assign nop_inc   = nop_q + 1'b1;
    // With a hold of one, the first NOP seen in RUN already terminates.
    assign term_run  = is_nop && (NOP_HOLD == 1);
    assign term_hold = is_nop && (nop_inc == NOP_TGT);
    assign ptr_ok    = (tos_ptr == exp_ptr);
    assign val_ok    = !val_chk_en || (tos_val == exp_val);

    // Channel FSM with its counters and registered verdict.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            nop_q   <= '0;
            res_q   <= '0;
        end else begin
            case (state_q)
                IDLE, FIN: begin
                    if (start) begin
                        state_q <= RUN;
                        cyc_q   <= '0;
                        nop_q   <= '0;
                        res_q   <= '0;
                    end
                end
                RUN: begin
                    cyc_q <= cyc_inc;
                    if (term_run) begin
                        state_q <= CHECK;
                    end else if (at_limit) begin
                        state_q       <= FIN;
                        res_q.timeout <= 1'b1;
                    end else if (is_nop) begin
                        state_q <= HOLD;
                        nop_q   <= NOP_ONE;
                    end
                end
                HOLD: begin
                    cyc_q <= cyc_inc;
                    if (term_hold) begin
                        state_q <= CHECK;
                        nop_q   <= nop_inc;
                    end else if (at_limit) begin
                        state_q       <= FIN;
                        res_q.timeout <= 1'b1;
                    end else if (is_nop) begin
                        nop_q <= nop_inc;
                    end else begin
                        state_q <= RUN;
                        nop_q   <= '0;
                    end
                end
                CHECK: begin
                    state_q    <= FIN;
                    res_q.pass <= ptr_ok && val_ok;
                    res_q.fail <= !(ptr_ok && val_ok);
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef CPU_RUN_MONITOR_CYCLES_EN
    logic [CYC_W-1:0] cycles_q;

    // cyc stops moving once CHECK or FIN is entered, so capture it there.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycles_q <= '0;
        end else if (start && (state_q == IDLE || state_q == FIN)) begin
            cycles_q <= '0;
        end else if (state_q == CHECK || state_q == FIN) begin
            cycles_q <= cyc_q;
        end
    end

    assign cycles = cycles_q;
`endif

    assign state_dbg = state_q;
    assign pass      = res_q.pass;
    assign fail      = res_q.fail;
    assign timeout   = res_q.timeout;

endmodule

// File: rtl/cpu_run_monitor.sv
// N-channel run/termination checker for parallel CPU instances.
// Optional build macro: CPU_RUN_MONITOR_CYCLES_EN adds the `cycles` output.
//
// Handshake: start is a one-cycle request, taken only when no channel is
// busy and the previous run is complete (done=1) or nothing has run yet
// (all channels IDLE); a start seen at any other time is dropped. done is
// the result-valid flag: while it is 1, pass/fail/timeout are stable and
// remain so until the next accepted start or rst.
import cpu_run_monitor_pkg::*;

module cpu_run_monitor #(
    parameter int NCH        = 7,
    parameter int MAX_CYCLES = 250,
    parameter int NOP_HOLD   = 4,
    parameter int CYC_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NCH*8-1:0]     op_code,
    input  logic [NCH*16-1:0]    tos_ptr,
    input  logic [NCH*32-1:0]    tos_val,
    input  logic [NCH*16-1:0]    exp_ptr,
    input  logic [NCH*32-1:0]    exp_val,
    input  logic [NCH-1:0]       val_chk_en,
    output logic                 busy,
    output logic                 done,
    output logic [NCH-1:0]       pass,
    output logic [NCH-1:0]       fail,
    output logic [NCH-1:0]       timeout
`ifdef CPU_RUN_MONITOR_CYCLES_EN
    ,
    output logic [NCH*CYC_W-1:0] cycles
`endif
);

    logic [NCH*3-1:0] state_v;
    logic [NCH-1:0]   active_v;
    logic [NCH-1:0]   idle_v;
    logic [NCH-1:0]   fin_v;
    logic             start_acc;
    logic             done_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        run_mon_channel #(
            .MAX_CYCLES (MAX_CYCLES),
            .NOP_HOLD   (NOP_HOLD),
            .CYC_W      (CYC_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .start      (start_acc),
            .op_code    (op_code[8*i +: 8]),
            .tos_ptr    (tos_ptr[16*i +: 16]),
            .tos_val    (tos_val[32*i +: 32]),
            .exp_ptr    (exp_ptr[16*i +: 16]),
            .exp_val    (exp_val[32*i +: 32]),
            .val_chk_en (val_chk_en[i]),
            .state_dbg  (state_v[3*i +: 3]),
            .pass       (pass[i]),
            .fail       (fail[i]),
            .timeout    (timeout[i])
`ifdef CPU_RUN_MONITOR_CYCLES_EN
            ,
            .cycles     (cycles[CYC_W*i +: CYC_W])
`endif
        );

        assign idle_v[i]   = (state_v[3*i +: 3] == IDLE);
        assign fin_v[i]    = (state_v[3*i +: 3] == FIN);
        assign active_v[i] = !idle_v[i] && !fin_v[i];
    end

    assign busy      = |active_v;
    assign start_acc = start && !busy && (done_q || (&idle_v));

    // done follows "every channel in FIN" by one cycle and drops on restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (&fin_v) && !start_acc;
        end
    end

    assign done = done_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
module tb_cpu_run_monitor;

  localparam int NCH  = 2;
  localparam int MAXC = 250;
  localparam int NH   = 4;
  localparam int CW   = 16;
  localparam int LEN  = 256;
  localparam int EW   = 16 * (NCH + 1) + 3 * NCH;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [NCH*8-1:0]  op_code = '0;
  logic [NCH*16-1:0] tos_ptr = '0;
  logic [NCH*32-1:0] tos_val = '0;
  logic [NCH*16-1:0] exp_ptr = '0;
  logic [NCH*32-1:0] exp_val = '0;
  logic [NCH-1:0]    val_chk_en = '0;
  logic              busy;
  logic              done;
  logic [NCH-1:0]    pass;
  logic [NCH-1:0]    fail;
  logic [NCH-1:0]    timeout;
`ifdef CPU_RUN_MONITOR_CYCLES_EN
  logic [NCH*CW-1:0] cycles;
`endif

  cpu_run_monitor #(
    .NCH        (NCH),
    .MAX_CYCLES (MAXC),
    .NOP_HOLD   (NH),
    .CYC_W      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_code    (op_code),
    .tos_ptr    (tos_ptr),
    .tos_val    (tos_val),
    .exp_ptr    (exp_ptr),
    .exp_val    (exp_val),
    .val_chk_en (val_chk_en),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .timeout    (timeout)
`ifdef CPU_RUN_MONITOR_CYCLES_EN
    ,
    .cycles     (cycles)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;

  int gcyc = 0;
  always @(posedge clk) gcyc <= gcyc + 1;

  // stimulus state shared by driver and monitor
  logic [7:0]    seq [NCH][LEN];
  logic [15:0]   c_ptr [NCH];
  logic [15:0]   c_eptr [NCH];
  logic [31:0]   c_val [NCH];
  logic [31:0]   c_eval [NCH];
  logic          c_en [NCH];
  int            t0 = 1 << 30;
  int            act_fin [NCH];
  logic [EW-1:0] exp_q [$];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // reference model: termination is the first cycle closing a run of NH NOPs
  function automatic int term_cycle(input int c);
    int run = 0;
    for (int k = 0; k < MAXC; k++) begin
      run = (seq[c][k] == 8'h00) ? run + 1 : 0;
      if (run >= NH) return k;
    end
    return -1;
  endfunction

  function automatic logic [EW-1:0] model();
    logic [EW-1:0] e = '0;
    int last = 0;
    for (int c = 0; c < NCH; c++) begin
      int t = term_cycle(c);
      int fin = (t >= 0) ? t + 2 : MAXC;
      logic ok = (c_ptr[c] == c_eptr[c]) && (!c_en[c] || c_val[c] == c_eval[c]);
      if (fin > last) last = fin;
      e[3*NCH + 16*c +: 16] = 16'(fin);
      e[2*NCH + c] = (t >= 0) && ok;
      e[NCH + c]   = (t >= 0) && !ok;
      e[c]         = (t < 0);
    end
    e[3*NCH + 16*NCH +: 16] = 16'(last + 1);
    return e;
  endfunction

  // stimulus builders
  task automatic fill_ops(input int c, input int nop_from);
    for (int k = 0; k < LEN; k++)
      seq[c][k] = (nop_from >= 0 && k >= nop_from) ? 8'h00 : 8'($urandom_range(1, 255));
  endtask

  task automatic fill_rand(input int c);
    int pct = $urandom_range(0, 60);
    for (int k = 0; k < LEN; k++)
      seq[c][k] = ($urandom_range(0, 99) < pct) ? 8'h00 : 8'($urandom_range(1, 255));
  endtask

  task automatic set_vals(input int c, input bit pmatch, input bit vmatch, input bit en);
    c_ptr[c]  = 16'($urandom_range(0, 15));
    c_eptr[c] = pmatch ? c_ptr[c] : c_ptr[c] + 16'd1;
    c_val[c]  = $urandom;
    c_eval[c] = vmatch ? c_val[c] : ~c_val[c];
    c_en[c]   = en;
  endtask

  // driver: one run, optional start-while-busy pulse and mid-run reset
  task automatic run_test(input string name, input bit push, input int busy_at, input int rst_at);
    logic [NCH-1:0] hp, hf, ht;
    for (int c = 0; c < NCH; c++) begin
      tos_ptr[16*c +: 16] = c_ptr[c];
      exp_ptr[16*c +: 16] = c_eptr[c];
      tos_val[32*c +: 32] = c_val[c];
      exp_val[32*c +: 32] = c_eval[c];
      val_chk_en[c]       = c_en[c];
    end
    if (push) exp_q.push_back(model());
    @(negedge clk);
    for (int c = 0; c < NCH; c++) act_fin[c] = -1;
    t0 = gcyc;
    start = 1'b1;
    for (int k = 0; k < LEN; k++) begin
      @(negedge clk);
      if (k == 0) chk({name, ".armed"}, {62'd0, busy, done}, 64'd2);
      if (k > 0 && done) break;
      if (rst_at >= 0 && k == rst_at + 1) begin
        rst = 1'b0;
        chk({name, ".rst_clear"}, {60'd0, busy, done, |pass, |fail, |timeout}, 64'd0);
        return;
      end
      start = (k == busy_at);
      rst = (k == rst_at);
      for (int c = 0; c < NCH; c++) op_code[8*c +: 8] = seq[c][k];
    end
    start = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s.done_wait actual=0 expected=1", name);
      return;
    end
    hp = pass; hf = fail; ht = timeout;
    repeat (3) begin
      @(negedge clk);
      chk({name, ".sticky"}, {61'd0, done, (pass == hp && fail == hf && timeout == ht), busy}, 64'd6);
    end
  endtask

  // monitor / scoreboard: compares when done rises
  initial begin
    logic done_d = 1'b0;
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && gcyc > t0)
        for (int c = 0; c < NCH; c++)
          if ((pass[c] | fail[c] | timeout[c]) && act_fin[c] < 0) act_fin[c] = gcyc - t0 - 1;
      if (done && !done_d) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 expected=0");
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", 64'(gcyc - t0 - 1), 64'(e[3*NCH + 16*NCH +: 16]));
          for (int c = 0; c < NCH; c++) begin
            chk($sformatf("fin_cycle%0d", c), 64'(act_fin[c]), 64'(e[3*NCH + 16*c +: 16]));
            chk($sformatf("onehot%0d", c), 64'(pass[c] + fail[c] + timeout[c]), 64'd1);
          end
          chk("pass", 64'(pass), 64'(e[2*NCH +: NCH]));
          chk("fail", 64'(fail), 64'(e[NCH +: NCH]));
          chk("timeout", 64'(timeout), 64'(e[0 +: NCH]));
        end
      end
      done_d = done;
    end
  end

  // main sequence
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {59'd0, busy, done, pass, fail, timeout}, 64'd0);

    // ch0: 8'h10 then NOP from cycle 20, depth matches
    for (int k = 0; k < LEN; k++) seq[0][k] = (k >= 20) ? 8'h00 : 8'h10;
    set_vals(0, 1, 1, 1);
    c_ptr[0] = 16'd2; c_eptr[0] = 16'd2;
    fill_ops(1, 60); set_vals(1, 1, 0, 0);
    run_test("basic", 1, -1, -1);

    // value mismatch with and without value check enabled
    for (int c = 0; c < NCH; c++) begin
      fill_ops(c, 30 + 7 * c);
      set_vals(c, 1, 0, 1);
      c_val[c] = 32'hcafe_babe; c_eval[c] = 32'hffff_cafe;
    end
    run_test("val_mismatch", 1, -1, -1);
    for (int c = 0; c < NCH; c++) c_en[c] = 1'b0;
    run_test("val_masked", 1, -1, -1);

    // NOP glitch: three NOPs, 8'h60, then held NOP
    for (int c = 0; c < NCH; c++) begin
      fill_ops(c, 34);
      seq[c][30] = 8'h00; seq[c][31] = 8'h00; seq[c][32] = 8'h00; seq[c][33] = 8'h60;
      set_vals(c, c == 0, 1, 1);
    end
    run_test("glitch", 1, -1, -1);

    // timeout on both channels
    for (int c = 0; c < NCH; c++) begin fill_ops(c, -1); set_vals(c, 1, 1, 1); end
    run_test("timeout", 1, -1, -1);

    // boundary: ch0 terminates on cycle MAXC-1, ch1 one NOP short
    fill_ops(0, MAXC - NH); set_vals(0, 1, 1, 1);
    fill_ops(1, MAXC - NH + 1); set_vals(1, 1, 1, 1);
    run_test("boundary", 1, -1, -1);

    // start while busy must be ignored
    for (int c = 0; c < NCH; c++) begin fill_ops(c, 90 + 20 * c); set_vals(c, 1, 1, 1); end
    run_test("busy_start", 1, 50, -1);

    // reset mid-run, then a fresh run
    for (int c = 0; c < NCH; c++) begin fill_ops(c, -1); set_vals(c, 1, 1, 1); end
    run_test("mid_rst", 0, -1, 100);
    for (int c = 0; c < NCH; c++) begin fill_ops(c, 40 + c); set_vals(c, 1, 1, 1); end
    run_test("after_rst", 1, -1, -1);

    // randomized runs
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < NCH; c++) begin
        fill_rand(c);
        set_vals(c, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
      end
      run_test($sformatf("rand%0d", r), 1, -1, -1);
    end

    repeat (2) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
